// File: rtl/ctrl_pkg.sv
// Shared constants for the microcode sequencer: opcodes, control-word bit map, idle/halt words.
// Active-low strobes sit at 1 in CW_IDLE; the optional early-end feature is CTRL_EARLY_END_EN.
package ctrl_pkg;

    localparam int NUM_STEPS_DEF = 5;

    typedef logic [2:0] step_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CB_HLT  = 15;
    localparam int CB_MI_N = 14;
    localparam int CB_RI   = 13;
    localparam int CB_RO_N = 12;
    localparam int CB_IO_N = 11;
    localparam int CB_II_N = 10;
    localparam int CB_AI_N = 9;
    localparam int CB_AO_N = 8;
    localparam int CB_EO_N = 7;
    localparam int CB_SU   = 6;
    localparam int CB_BI_N = 5;
    localparam int CB_OI_N = 4;
    localparam int CB_CE   = 3;
    localparam int CB_CO_N = 2;
    localparam int CB_J_N  = 1;
    localparam int CB_FI   = 0;

    localparam logic [15:0] CW_IDLE = 16'h5FB6;
    localparam logic [15:0] CW_HALT = CW_IDLE | 16'h8000;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode ROM: (opcode, T-state, flags) -> control word and last-step flag.
// With CTRL_EARLY_END_EN defined, `last` marks each instruction's final active step; otherwise it stays 0.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0]  I,
    input  logic [2:0]  step,
    input  logic        cf,
    input  logic        zf,
    output logic [15:0] ctrl,
    output logic        last
);

    always_comb begin
        ctrl = CW_IDLE;
        case (step)
            3'd0: begin
                ctrl[CB_CO_N] = 1'b0;
                ctrl[CB_MI_N] = 1'b0;
            end
            3'd1: begin
                ctrl[CB_RO_N] = 1'b0;
                ctrl[CB_II_N] = 1'b0;
                ctrl[CB_CE]   = 1'b1;
            end
            3'd2: begin
                // Flags only matter here; later steps never look at cf/zf.
                case (I)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[CB_IO_N] = 1'b0;
                        ctrl[CB_MI_N] = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl[CB_IO_N] = 1'b0;
                        ctrl[CB_AI_N] = 1'b0;
                    end
                    OP_JMP: begin
                        ctrl[CB_IO_N] = 1'b0;
                        ctrl[CB_J_N]  = 1'b0;
                    end
                    OP_JC: begin
                        ctrl[CB_IO_N] = 1'b0;
                        ctrl[CB_J_N]  = ~cf;
                    end
                    OP_JZ: begin
                        ctrl[CB_IO_N] = 1'b0;
                        ctrl[CB_J_N]  = ~zf;
                    end
                    OP_OUT: begin
                        ctrl[CB_AO_N] = 1'b0;
                        ctrl[CB_OI_N] = 1'b0;
                    end
                    OP_HLT: ctrl[CB_HLT] = 1'b1;
                    default: ;
                endcase
            end
            3'd3: begin
                case (I)
                    OP_LDA: begin
                        ctrl[CB_RO_N] = 1'b0;
                        ctrl[CB_AI_N] = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[CB_RO_N] = 1'b0;
                        ctrl[CB_BI_N] = 1'b0;
                    end
                    OP_STA: begin
                        ctrl[CB_AO_N] = 1'b0;
                        ctrl[CB_RI]   = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd4: begin
                if (I == OP_ADD || I == OP_SUB) begin
                    ctrl[CB_EO_N] = 1'b0;
                    ctrl[CB_AI_N] = 1'b0;
                    ctrl[CB_FI]   = 1'b1;
                    ctrl[CB_SU]   = (I == OP_SUB);
                end
            end
            default: ;
        endcase
    end

`ifdef CTRL_EARLY_END_EN
    always_comb begin
        case (I)
            OP_LDA, OP_STA: last = (step == 3'd3);
            OP_ADD, OP_SUB: last = (step == 3'd4);
            default:        last = (step == 3'd2);
        endcase
    end
`else
    assign last = 1'b0;
`endif

endmodule

// File: rtl/ctrl_sequencer.sv
// T-state counter, halt latch and reset forcing around the microcode ROM; ctrl is combinational.
// Early instruction end is enabled by defining CTRL_EARLY_END_EN (see ctrl_decode).
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int NUM_STEPS = NUM_STEPS_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  I,
    input  logic        cf,
    input  logic        zf,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

    step_t      step_q, step_d;
    run_state_t state_q, state_d;
    logic [15:0] dec_ctrl;
    logic        dec_last;

    ctrl_decode u_decode (
        .I    (I),
        .step (step_q),
        .cf   (cf),
        .zf   (zf),
        .ctrl (dec_ctrl),
        .last (dec_last)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ctrl    = dec_ctrl;
        case (state_q)
            ST_RUN: begin
                // HLT freezes the counter on T2 rather than wrapping.
                if (dec_ctrl[CB_HLT]) begin
                    state_d = ST_HALT;
                end else if (dec_last || step_q == LAST_STEP) begin
                    step_d = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_HALT: ctrl = CW_HALT;
            default: state_d = ST_RUN;
        endcase
        if (clr) begin
            ctrl = CW_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            step_q  <= '0;
            state_q <= ST_RUN;
        end else begin
            step_q  <= step_d;
            state_q <= state_d;
        end
    end

    assign step   = step_q;
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized bench for ctrl_sequencer against a table-driven microprogram model.
module tb_ctrl_sequencer;

    localparam logic [15:0] IDLE_W = 16'h5FB6;
    localparam int S_HLT = 15, S_MI = 14, S_RI = 13, S_RO = 12, S_IO = 11, S_II = 10;
    localparam int S_AI = 9, S_AO = 8, S_EO = 7, S_SU = 6, S_BI = 5, S_OI = 4;
    localparam int S_CE = 3, S_CO = 2, S_J = 1, S_FI = 0;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  I   = 4'd0;
    logic        cf  = 1'b0;
    logic        zf  = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    ctrl_sequencer dut (
        .clk    (clk),
        .clr    (clr),
        .I      (I),
        .cf     (cf),
        .zf     (zf),
        .ctrl   (ctrl),
        .step   (step),
        .halted (halted)
    );

    always #5 clk = ~clk;

    // One microprogram entry: strobe `sig` asserted for opcode `op` (-1 = every opcode)
    // at T-state `stp`; cond 0 = always, 1 = only with cf, 2 = only with zf.
    typedef struct {
        int op;
        int stp;
        int sig;
        int cond;
    } uop_t;

    uop_t       ucode[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         exp_step = 0;
    bit         exp_halted = 1'b0;
    logic [3:0] cur_op = 4'd0;
    bit         saw_eo = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (op %h step %0d)", tag, got, exp, cur_op, exp_step);
    endtask

    task automatic add(input int op, input int stp, input int sig, input int cond);
        uop_t u;
        u.op = op; u.stp = stp; u.sig = sig; u.cond = cond;
        ucode.push_back(u);
    endtask

    function automatic logic [15:0] model_cw(input int op, input int stp, input logic c, input logic z);
        logic [15:0] w;
        logic [15:0] idle_v;
        idle_v = IDLE_W;
        w = idle_v;
        foreach (ucode[k]) begin
            if ((ucode[k].op == -1 || ucode[k].op == op) && ucode[k].stp == stp &&
                (ucode[k].cond == 0 || (ucode[k].cond == 1 && c) || (ucode[k].cond == 2 && z)))
                w[ucode[k].sig] = ~idle_v[ucode[k].sig];
        end
        return w;
    endfunction

    // Cycles an instruction occupies: fixed slot, or up to its last listed strobe (at least T2).
    function automatic int model_len(input int op);
`ifdef CTRL_EARLY_END_EN
        int last = 2;
        foreach (ucode[k])
            if (ucode[k].op == op && ucode[k].stp > last) last = ucode[k].stp;
        return last + 1;
`else
        return (op >= 0) ? 5 : 5;
`endif
    endfunction

    task automatic tick(input bit rst, input bit pin, input logic cfv, input logic zfv);
        logic [15:0] exp_cw;
        @(posedge clk);
        #1;
        clr = rst;
        I   = (exp_step < 2 || exp_halted) ? 4'($urandom) : cur_op;
        cf  = (pin && exp_step == 2) ? cfv : 1'($urandom);
        zf  = (pin && exp_step == 2) ? zfv : 1'($urandom);
        #1;
        if (rst)             exp_cw = IDLE_W;
        else if (exp_halted) exp_cw = IDLE_W | 16'h8000;
        else                 exp_cw = model_cw(int'(cur_op), exp_step, cf, zf);
        check("ctrl", ctrl, exp_cw);
        check("step", 16'(step), 16'(exp_step));
        check("halted", 16'(halted), 16'(exp_halted));
        if (ctrl[S_EO] == 1'b0) saw_eo = 1'b1;
        if (rst) begin
            exp_step   = 0;
            exp_halted = 1'b0;
        end else if (exp_halted) begin
            exp_step = exp_step;
        end else if (exp_step == 2 && cur_op == 4'hF) begin
            exp_halted = 1'b1;
        end else if (exp_step == model_len(int'(cur_op)) - 1) begin
            exp_step = 0;
        end else begin
            exp_step++;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic cfv, input logic zfv);
        cur_op = op;
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, 1'b1, cfv, zfv);
            if (exp_step == 0 || exp_halted) break;
        end
        check("instr_end", 16'(exp_step == 0 || exp_halted), 16'd1);
    endtask

    initial begin
        add(-1, 0, S_CO, 0); add(-1, 0, S_MI, 0);
        add(-1, 1, S_RO, 0); add(-1, 1, S_II, 0); add(-1, 1, S_CE, 0);
        add(1, 2, S_IO, 0); add(1, 2, S_MI, 0); add(1, 3, S_RO, 0); add(1, 3, S_AI, 0);
        for (int op = 2; op <= 3; op++) begin
            add(op, 2, S_IO, 0); add(op, 2, S_MI, 0);
            add(op, 3, S_RO, 0); add(op, 3, S_BI, 0);
            add(op, 4, S_EO, 0); add(op, 4, S_AI, 0); add(op, 4, S_FI, 0);
        end
        add(3, 4, S_SU, 0);
        add(4, 2, S_IO, 0); add(4, 2, S_MI, 0); add(4, 3, S_AO, 0); add(4, 3, S_RI, 0);
        add(5, 2, S_IO, 0); add(5, 2, S_AI, 0);
        add(6, 2, S_IO, 0); add(6, 2, S_J, 0);
        add(7, 2, S_IO, 0); add(7, 2, S_J, 1);
        add(8, 2, S_IO, 0); add(8, 2, S_J, 2);
        add(14, 2, S_AO, 0); add(14, 2, S_OI, 0);
        add(15, 2, S_HLT, 0);

        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        run_instr(4'h1, 1'b0, 1'b0);
        run_instr(4'h3, 1'b1, 1'b1);
        run_instr(4'h7, 1'b0, 1'b1);
        run_instr(4'h7, 1'b1, 1'b0);
        run_instr(4'h8, 1'b1, 1'b0);
        run_instr(4'h8, 1'b0, 1'b1);
        for (int op = 0; op < 15; op++)
            run_instr(4'(op), 1'($urandom), 1'($urandom));
        for (int n = 0; n < 150; n++)
            run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom));

        // Abort an ADD at T3: no eo_n strobe may appear from then on.
        cur_op = 4'h2;
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_at_t3", 16'(exp_step), 16'd3);
        saw_eo = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        run_instr(4'h5, 1'b0, 1'b0);
        check("abort_no_eo", 16'(saw_eo), 16'd0);

        run_instr(4'hF, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++)
            run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
